// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_pkg;

    localparam int unsigned NumRegs  = 32;
    localparam int unsigned RegAddrW = 5;

    // Load result formatting applied by the register-file write port
    typedef enum logic [2:0] {
        FMT_W  = 3'd0,
        FMT_B  = 3'd1,
        FMT_H  = 3'd2,
        FMT_BU = 3'd3,
        FMT_HU = 3'd4
    } ld_fmt_e;

    // Which side won the most recent contended arbitration
    typedef enum logic {
        GrantAlu = 1'b0,
        GrantLd  = 1'b1
    } grant_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bundle: ALU and load handshakes into the arbiter.
// Signal suffixes are from the arbiter's point of view.
interface rf_wb_arbiter_if
    import rf_pkg::*;
#(
    parameter int unsigned Width = 32
) ();

    logic                alu_valid_i;
    logic                alu_ready_o;
    logic [RegAddrW-1:0] alu_rd_i;
    logic [Width-1:0]    alu_data_i;

    logic                ld_valid_i;
    logic                ld_ready_o;
    logic [RegAddrW-1:0] ld_rd_i;
    logic [Width-1:0]    ld_data_i;
    ld_fmt_e             ld_fmt_i;

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  ld_valid_i, ld_rd_i, ld_data_i, ld_fmt_i,
        output alu_ready_o, ld_ready_o
    );

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output ld_valid_i, ld_rd_i, ld_data_i, ld_fmt_i,
        input  alu_ready_o, ld_ready_o
    );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding pending load writebacks.
// Depth must be a power of two so the pointers wrap naturally.
module wb_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic [CntW-1:0]  count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Next pointers and occupancy; push+pop together leaves count unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Pointer and count state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are don't-care while the slot is not occupied
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: merges an unbuffered ALU path and a
// buffered load path onto one RF write port, and tracks loads in flight
// so decode can detect read-after-load hazards.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned Width   = 32,
    parameter int unsigned LdDepth = 2,
    localparam int unsigned CntW   = $clog2(LdDepth) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    rf_wb_arbiter_if.slave      wb,
    input  logic                ld_issue_i,
    input  logic [RegAddrW-1:0] ld_issue_rd_i,
    input  logic [RegAddrW-1:0] ra_i,
    input  logic [RegAddrW-1:0] rb_i,
    output logic                hazard_a_o,
    output logic                hazard_b_o,
    output logic                rf_we_o,
    output logic [RegAddrW-1:0] rf_rw_o,
    output logic [Width-1:0]    rf_wdata_o,
    ld_fmt_e                    rf_fmt_o,
    output logic [CntW-1:0]     ld_count_o
);

    localparam int unsigned EntW = Width + RegAddrW + 3;

    logic [EntW-1:0]     fifo_wdata;
    logic [EntW-1:0]     fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;

    logic [Width-1:0]    head_data;
    logic [RegAddrW-1:0] head_rd;
    ld_fmt_e             head_fmt;

    logic                alu_cand;
    logic                ld_cand;
    logic                grant_alu;
    logic                grant_ld;
    grant_e              last_grant_q, last_grant_d;

    logic [NumRegs-1:0]  pending_q, pending_d;

    logic                rf_we_q, rf_we_d;
    logic [RegAddrW-1:0] rf_rw_q, rf_rw_d;
    logic [Width-1:0]    rf_wdata_q, rf_wdata_d;
    ld_fmt_e             rf_fmt_q, rf_fmt_d;

    assign fifo_wdata = {wb.ld_fmt_i, wb.ld_rd_i, wb.ld_data_i};
    assign fifo_push  = wb.ld_valid_i & wb.ld_ready_o;

    assign head_data = fifo_rdata[Width-1:0];
    assign head_rd   = fifo_rdata[Width +: RegAddrW];
    assign head_fmt  = ld_fmt_e'(fifo_rdata[Width + RegAddrW +: 3]);

    wb_fifo #(
        .Width (EntW),
        .Depth (LdDepth)
    ) u_ld_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (grant_ld),
        .rdata_o (fifo_rdata),
        .count_o (ld_count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Arbitration: full FIFO wins a tie, otherwise alternate on contention
    always_comb begin
        grant_alu    = 1'b0;
        grant_ld     = 1'b0;
        last_grant_d = last_grant_q;
        alu_cand     = wb.alu_valid_i & ~rst_i;
        ld_cand      = ~fifo_empty & ~rst_i;
        if (alu_cand && ld_cand) begin
            if (fifo_full || (last_grant_q == GrantAlu)) begin
                grant_ld = 1'b1;
            end else begin
                grant_alu = 1'b1;
            end
            last_grant_d = grant_ld ? GrantLd : GrantAlu;
        end else begin
            grant_alu = alu_cand;
            grant_ld  = ld_cand;
        end
    end

    assign wb.alu_ready_o = grant_alu;
    assign wb.ld_ready_o  = ~rst_i & ~fifo_full;

    // Next RF write port value; rd==0 completes the transfer without a write
    always_comb begin
        rf_we_d    = 1'b0;
        rf_rw_d    = rf_rw_q;
        rf_wdata_d = rf_wdata_q;
        rf_fmt_d   = rf_fmt_q;
        if (grant_alu) begin
            rf_we_d    = (wb.alu_rd_i != '0);
            rf_rw_d    = wb.alu_rd_i;
            rf_wdata_d = wb.alu_data_i;
            rf_fmt_d   = FMT_W;
        end else if (grant_ld) begin
            rf_we_d    = (head_rd != '0);
            rf_rw_d    = head_rd;
            rf_wdata_d = head_data;
            rf_fmt_d   = head_fmt;
        end
    end

    // Pending-load scoreboard; a same-cycle issue to the retiring reg wins
    always_comb begin
        pending_d = pending_q;
        if (grant_ld) begin
            pending_d[head_rd] = 1'b0;
        end
        if (ld_issue_i && (ld_issue_rd_i != '0)) begin
            pending_d[ld_issue_rd_i] = 1'b1;
        end
    end

    // Arbiter, scoreboard and RF port registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= GrantLd;
            pending_q    <= '0;
            rf_we_q      <= 1'b0;
            rf_rw_q      <= '0;
            rf_wdata_q   <= '0;
            rf_fmt_q     <= FMT_W;
        end else begin
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            rf_we_q      <= rf_we_d;
            rf_rw_q      <= rf_rw_d;
            rf_wdata_q   <= rf_wdata_d;
            rf_fmt_q     <= rf_fmt_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_rw_o    = rf_rw_q;
    assign rf_wdata_o = rf_wdata_q;
    assign rf_fmt_o   = rf_fmt_q;

    // Read hazard: load still outstanding, or being written this cycle
    always_comb begin
        hazard_a_o = (ra_i != '0) & (pending_q[ra_i] | (rf_we_q & (rf_rw_q == ra_i)));
        hazard_b_o = (rb_i != '0) & (pending_q[rb_i] | (rf_we_q & (rf_rw_q == rb_i)));
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios with literal
// expectations, plus a queue-based reference model compared every cycle.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic [4:0]  ra, rb;
    logic        hazard_a, hazard_b;
    logic        rf_we;
    logic [4:0]  rf_rw;
    logic [W-1:0] rf_wdata;
    ld_fmt_e     rf_fmt;
    logic [1:0]  ld_count;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    rf_wb_arbiter_if #(.Width(W)) wb_if ();

    rf_wb_arbiter #(
        .Width   (W),
        .LdDepth (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .wb            (wb_if),
        .ld_issue_i    (ld_issue),
        .ld_issue_rd_i (ld_issue_rd),
        .ra_i          (ra),
        .rb_i          (rb),
        .hazard_a_o    (hazard_a),
        .hazard_b_o    (hazard_b),
        .rf_we_o       (rf_we),
        .rf_rw_o       (rf_rw),
        .rf_wdata_o    (rf_wdata),
        .rf_fmt_o      (rf_fmt),
        .ld_count_o    (ld_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        logic [4:0]   rd;
        logic [W-1:0] data;
        logic [2:0]   fmt;
    } ent_t;

    ent_t         ldq[$];
    bit [31:0]    pend;
    bit           last_alu;
    bit           ewe;
    logic [4:0]   erw;
    logic [W-1:0] ewd;
    logic [2:0]   efmt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Who wins this cycle, straight from the priority rules
    function automatic void mgrant(output bit ga, output bit gl);
        bit ac, lc;
        ac = wb_if.alu_valid_i && !rst;
        lc = (ldq.size() > 0) && !rst;
        ga = 0;
        gl = 0;
        if (ac && lc) begin
            if (ldq.size() == DEPTH) gl = 1;
            else if (last_alu) gl = 1;
            else ga = 1;
        end else begin
            ga = ac;
            gl = lc;
        end
    endfunction

    function automatic bit mhaz(input logic [4:0] r);
        return (r != 0) && (pend[r] || (ewe && erw == r));
    endfunction

    // Model state update at each active edge
    always @(posedge clk) begin
        bit ga, gl, both, push;
        ent_t head;
        mgrant(ga, gl);
        if (rst) begin
            ldq.delete();
            pend     = 0;
            last_alu = 0;
            ewe      = 0;
            erw      = 0;
            ewd      = 0;
            efmt     = FMT_W;
        end else begin
            both = wb_if.alu_valid_i && (ldq.size() > 0);
            push = wb_if.ld_valid_i && (ldq.size() < DEPTH);
            if (gl) begin
                head = ldq.pop_front();
                pend[head.rd] = 0;
            end
            if (push) ldq.push_back('{wb_if.ld_rd_i, wb_if.ld_data_i, wb_if.ld_fmt_i});
            if (ld_issue && ld_issue_rd != 0) pend[ld_issue_rd] = 1;
            if (both) last_alu = ga;
            if (ga) begin
                ewe  = (wb_if.alu_rd_i != 0);
                erw  = wb_if.alu_rd_i;
                ewd  = wb_if.alu_data_i;
                efmt = FMT_W;
            end else if (gl) begin
                ewe  = (head.rd != 0);
                erw  = head.rd;
                ewd  = head.data;
                efmt = head.fmt;
            end else begin
                ewe = 0;
            end
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin
        bit ga, gl;
        if (started) begin
            mgrant(ga, gl);
            chk("alu_ready", wb_if.alu_ready_o, ga);
            chk("ld_ready", wb_if.ld_ready_o, !rst && ldq.size() < DEPTH);
            chk("ld_count", ld_count, ldq.size());
            chk("rf_we", rf_we, ewe);
            chk("rf_rw", rf_rw, erw);
            chk("rf_wdata", rf_wdata, ewd);
            chk("rf_fmt", rf_fmt, efmt);
            chk("hazard_a", hazard_a, mhaz(ra));
            chk("hazard_b", hazard_b, mhaz(rb));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_if.alu_valid_i = 0;
        wb_if.alu_rd_i    = 0;
        wb_if.alu_data_i  = 0;
        wb_if.ld_valid_i  = 0;
        wb_if.ld_rd_i     = 0;
        wb_if.ld_data_i   = 0;
        wb_if.ld_fmt_i    = FMT_W;
        ld_issue          = 0;
        ld_issue_rd       = 0;
        ra                = 0;
        rb                = 0;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [W-1:0] d);
        wb_if.alu_valid_i = v;
        wb_if.alu_rd_i    = rd;
        wb_if.alu_data_i  = d;
    endtask

    task automatic ld(input logic v, input logic [4:0] rd, input logic [W-1:0] d,
                      input ld_fmt_e f);
        wb_if.ld_valid_i = v;
        wb_if.ld_rd_i    = rd;
        wb_if.ld_data_i  = d;
        wb_if.ld_fmt_i   = f;
    endtask

    task automatic do_reset();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        cyc();
        started = 1;
        // Ready outputs held low while reset is asserted
        alu(1, 5'd3, 32'h1);
        ld(1, 5'd4, 32'h2, FMT_W);
        #1;
        chk("rst_alu_ready", wb_if.alu_ready_o, 0);
        chk("rst_ld_ready", wb_if.ld_ready_o, 0);
        cyc();
        idle_inputs();
        rst = 0;
        #1;
        chk("reset_count", ld_count, 0);
        chk("reset_we", rf_we, 0);
        chk("reset_fmt", rf_fmt, FMT_W);
        chk("reset_wdata", rf_wdata, 0);

        // Lone ALU write, latency one
        alu(1, 5'd5, 32'h1234);
        #1;
        chk("alu_alone_ready", wb_if.alu_ready_o, 1);
        cyc();
        alu(0, 0, 0);
        chk("alu_we", rf_we, 1);
        chk("alu_rw", rf_rw, 5);
        chk("alu_wdata", rf_wdata, 32'h1234);
        chk("alu_fmt", rf_fmt, FMT_W);
        cyc();
        chk("idle_we", rf_we, 0);
        chk("idle_hold", rf_wdata, 32'h1234);

        // Load hazard tracking through the write cycle
        ld_issue = 1;
        ld_issue_rd = 5'd7;
        cyc();
        ld_issue = 0;
        ra = 5'd7;
        rb = 5'd7;
        #1;
        chk("haz_pending", hazard_a, 1);
        ld(1, 5'd7, 32'hAB, FMT_B);
        cyc();
        ld(0, 0, 0, FMT_W);
        #1;
        chk("haz_queued", hazard_a, 1);
        cyc();
        chk("haz_we_cycle", hazard_a, 1);
        chk("ld_we", rf_we, 1);
        chk("ld_rw", rf_rw, 7);
        chk("ld_fmt", rf_fmt, FMT_B);
        chk("ld_wdata", rf_wdata, 32'hAB);
        cyc();
        chk("haz_cleared", hazard_a, 0);
        ra = 0;
        rb = 0;

        // Contended grants alternate, ALU first
        alu(1, 5'd10, 32'hA0);
        ld(1, 5'd11, 32'hB1, FMT_H);
        #1;
        chk("alt_a", wb_if.alu_ready_o, 1);
        cyc();
        ld(0, 0, 0, FMT_W);
        alu(1, 5'd10, 32'hA1);
        #1;
        chk("alt_b", wb_if.alu_ready_o, 1);
        cyc();
        ld(1, 5'd12, 32'hB2, FMT_HU);
        #1;
        chk("alt_c", wb_if.alu_ready_o, 0);
        cyc();
        chk("alt_c_rw", rf_rw, 11);
        chk("alt_c_fmt", rf_fmt, FMT_H);
        ld(0, 0, 0, FMT_W);
        #1;
        chk("alt_d", wb_if.alu_ready_o, 1);
        cyc();
        ld(1, 5'd13, 32'hB3, FMT_B);
        #1;
        chk("alt_e", wb_if.alu_ready_o, 0);
        cyc();
        chk("alt_e_rw", rf_rw, 12);
        ld(0, 0, 0, FMT_W);
        #1;
        chk("alt_f", wb_if.alu_ready_o, 1);
        cyc();
        alu(0, 0, 0);
        cyc();
        cyc();

        // Fill FIFO behind a busy ALU; full FIFO wins
        do_reset();
        alu(1, 5'd14, 32'hC0);
        ld(1, 5'd15, 32'hD1, FMT_BU);
        #1;
        chk("fill1_alu", wb_if.alu_ready_o, 1);
        chk("fill1_ld", wb_if.ld_ready_o, 1);
        cyc();
        ld(1, 5'd16, 32'hD2, FMT_W);
        #1;
        chk("fill2_alu", wb_if.alu_ready_o, 1);
        chk("fill2_ld", wb_if.ld_ready_o, 1);
        cyc();
        ld(1, 5'd17, 32'hD3, FMT_H);
        #1;
        chk("full_ld_ready", wb_if.ld_ready_o, 0);
        chk("full_alu_ready", wb_if.alu_ready_o, 0);
        chk("full_count", ld_count, 2);
        cyc();
        chk("full_win_rw", rf_rw, 15);
        chk("full_win_fmt", rf_fmt, FMT_BU);
        chk("after_full_ready", wb_if.ld_ready_o, 1);
        cyc();
        alu(0, 0, 0);
        ld(0, 0, 0, FMT_W);
        repeat (4) cyc();

        // rd==0 writes and issues are inert
        alu(1, 5'd0, 32'hFF);
        #1;
        chk("rd0_ready", wb_if.alu_ready_o, 1);
        cyc();
        alu(0, 0, 0);
        chk("rd0_we", rf_we, 0);
        ld_issue = 1;
        ld_issue_rd = 0;
        cyc();
        ld_issue = 0;
        ra = 0;
        #1;
        chk("rd0_hazard", hazard_a, 0);

        // Reset discards buffered loads and pending bits
        do_reset();
        alu(1, 5'd18, 32'hE9);
        ld(1, 5'd20, 32'hE0, FMT_W);
        ld_issue = 1;
        ld_issue_rd = 5'd9;
        cyc();
        ld_issue = 0;
        ld(1, 5'd21, 32'hE1, FMT_W);
        cyc();
        ld(0, 0, 0, FMT_W);
        ra = 5'd9;
        #1;
        chk("pre_rst_count", ld_count, 2);
        chk("pre_rst_haz", hazard_a, 1);
        rst = 1;
        #1;
        chk("in_rst_alu_ready", wb_if.alu_ready_o, 0);
        cyc();
        rst = 0;
        alu(0, 0, 0);
        #1;
        chk("post_rst_count", ld_count, 0);
        chk("post_rst_haz", hazard_a, 0);
        chk("post_rst_we", rf_we, 0);

        // Mixed traffic, checked by the model only
        for (int i = 0; i < 200; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            alu($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom);
            ld($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
               ld_fmt_e'(3'($urandom_range(0, 4))));
            ld_issue    = $urandom_range(0, 1);
            ld_issue_rd = 5'($urandom_range(0, 31));
            ra          = 5'($urandom_range(0, 31));
            rb          = 5'($urandom_range(0, 31));
            cyc();
        end
        idle_inputs();
        rst = 0;
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
